instr_fetch_mem: RTL and testbench
==================================

Name: instr_fetch_mem

Overview:
Parametrised, loadable instruction memory with a pipelined fetch port for the single-cycle CPU. It replaces the ad-hoc behavioural instruction array with synthesizable RTL.
- A loader streams a program in sequentially after reset or reload.
- The CPU then issues one fetch per cycle and receives the instruction after a fixed latency, with a valid flag.

Parameters:
INSTR_WIDTH, 19, instruction word width in bits
ADDR_WIDTH, 7, word-address width; DEPTH = 2**ADDR_WIDTH (128)
PC_WIDTH, 32, width of the CPU program counter
READ_LATENCY, 1, cycles from fetch_req to instr_valid; legal range 1..4
FILL_INSTR, 0, word returned for out-of-range PC

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
PC  in  PC_WIDTH  word address of the fetch
fetch_req  in  1  fetch request, sampled with PC
INSTRUCTION  out  INSTR_WIDTH  fetched word, registered
instr_valid  out  1  INSTRUCTION valid this cycle (1-cycle pulse per request)
addr_fault  out  1  PC >= DEPTH for the word returned this cycle
busy  out  1  memory is loading; fetches are ignored
load_valid  in  1  loader word present
load_data  in  INSTR_WIDTH  loader word
load_last  in  1  final word of the program
load_ready  out  1  loader word accepted this cycle
load_done  out  1  sticky; high once a load completes, until the next reload or RESET
reload  in  1  restart loading at address 0

Behaviour:
- FSM states are LOAD and RUN.
- RESET:
  - state=LOAD, load_addr=0.
  - INSTRUCTION=FILL_INSTR, instr_valid=0, addr_fault=0, busy=1, load_ready=1, load_done=0.
  - The read pipeline is cleared. Memory contents are not cleared.
- LOAD state:
  - busy=1, load_ready=1.
  - On load_valid: mem[load_addr]<=load_data, then load_addr++.
  - On an accepted word with load_last=1, or with load_addr==DEPTH-1: next state RUN, load_done<=1, load_addr<=0.
  - No write can wrap past DEPTH-1.
- RUN state:
  - busy=0, load_ready=0. load_valid is ignored.
- Fetch:
  - fetch_req is accepted only in RUN. In LOAD it is dropped with no response.
  - A request accepted at edge t produces instr_valid=1 on the cycle after edge t+READ_LATENCY-1.
  - The port is fully pipelined: back-to-back requests give back-to-back valids in request order.
  - Index is PC[ADDR_WIDTH-1:0]. If PC >= DEPTH, the response is INSTRUCTION=FILL_INSTR with addr_fault=1 in the same cycle as instr_valid.
  - INSTRUCTION holds its last value when instr_valid=0.
- Reload:
  - A reload pulse in any state gives next state LOAD, load_addr=0, load_done=0.
  - All in-flight fetches are squashed and produce no valid.
  - reload beats a same-cycle fetch_req or load_valid.
- RESET mid-load: partial contents are kept and loading restarts at address 0.
- RESET mid-fetch: in-flight fetches are discarded.
- Latency is checked at elaboration: READ_LATENCY outside 1..4 is a fatal error.

Optional Feature:
IMEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed at load time.
  - Parity is checked on read. A mismatch asserts port parity_err (out, 1) coincident with instr_valid, and INSTRUCTION is forced to FILL_INSTR.
  - A second mismatch while parity_err is already high is still reported per word.
- Undefined: no parity storage, and the parity_err port is absent.

Decomposition:
- Shared package imem_pkg:
  - FSM state encoding (S_LOAD=0, S_RUN=1).
  - READ_LATENCY bounds (1 and 4).
  - Default FILL_INSTR (all-zero NOP).
- Sub-module imem_read_pipe:
  - Parametrised valid/data/fault shift pipeline of depth READ_LATENCY.
  - Has a synchronous flush input driven by RESET or reload.

Test Plan:
- Load program, then fetch, READ_LATENCY=1: reset, load 7 words 0x40402, 0x40C21, 0x00443, 0x09024, 0x48002, 0x41011, 0x4100A with load_last on word 6 -> busy falls the cycle after word 6 and load_done=1. Fetch PC=0..6 back-to-back -> 7 consecutive valids with matching data, each one cycle after its request.
- Latency sweep READ_LATENCY=1..4: single fetch PC=3 -> instr_valid exactly READ_LATENCY cycles later with 0x09024, and no other valid pulses.
- Out-of-range fetch: PC=200 with DEPTH=128 -> INSTRUCTION=FILL_INSTR and addr_fault=1 with instr_valid. The next fetch of PC=2 returns 0x00443 with addr_fault=0.
- Reload mid-stream: issue PC=0,1,2 with reload asserted in the PC=1 request cycle, READ_LATENCY=3 -> at most the PC=0 response is seen, then busy=1, load_done=0. Reload 1 word, 0x7FFFF, with load_last -> a fetch of PC=0 returns 0x7FFFF.
- Full-depth load without load_last: 128 words with data=address -> auto transition to RUN after word 127. A fetch of PC=127 returns 127.
- RESET during LOAD after 3 words, then fetch in LOAD: fetch_req gives no instr_valid, and load_addr restarts at 0. With IMEM_PARITY_EN, flip a stored bit via force -> parity_err=1 and INSTRUCTION=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM encoding,
// legal read-latency bounds and the default fill word (all-zero NOP).
package imem_pkg;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } imem_state_e;

  localparam int RD_LAT_MIN = 32'sd1;
  localparam int RD_LAT_MAX = 32'sd4;

  localparam logic [63:0] FILL_INSTR_DEFAULT = 64'd0;

endpackage

// File: rtl/imem_read_pipe.sv
// Valid/data/flag shift pipeline of depth LATENCY. Data holds when no valid
// passes a stage; flags are qualified by valid so they only pulse with it.
module imem_read_pipe
#(
  parameter int                DATA_W     = 19,
  parameter int                FLAG_W     = 1,
  parameter int                LATENCY    = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
)
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [FLAG_W-1:0] flags_o
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  data_q [LATENCY];
  logic [FLAG_W-1:0]  flag_q [LATENCY];

  logic [LATENCY-1:0] vin_s;
  logic [DATA_W-1:0]  din_s [LATENCY];
  logic [FLAG_W-1:0]  fin_s [LATENCY];

  // Stage inputs; a flush kills every valid about to advance
  always_comb begin
    vin_s = '0;
    for (int i = 0; i < LATENCY; i++) begin
      din_s[i] = '0;
      fin_s[i] = '0;
    end
    vin_s[0] = valid_i & ~flush_i;
    din_s[0] = data_i;
    fin_s[0] = flags_i;
    for (int i = 1; i < LATENCY; i++) begin
      vin_s[i] = vld_q[i-1] & ~flush_i;
      din_s[i] = data_q[i-1];
      fin_s[i] = flag_q[i-1];
    end
  end

  // Stage registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= RESET_DATA;
        flag_q[i] <= '0;
      end
    end else begin
      vld_q <= vin_s;
      for (int i = 0; i < LATENCY; i++) begin
        if (vin_s[i]) begin
          data_q[i] <= din_s[i];
          flag_q[i] <= fin_s[i];
        end else begin
          flag_q[i] <= '0;
        end
      end
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];
  assign flags_o = flag_q[LATENCY-1];

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a pipelined fetch port.
// Optional build macro IMEM_PARITY_EN adds a stored even-parity bit and parity_err.
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int                     INSTR_WIDTH  = 19,
  parameter int                     ADDR_WIDTH   = 7,
  parameter int                     PC_WIDTH     = 32,
  parameter int                     READ_LATENCY = 1,
  parameter logic [INSTR_WIDTH-1:0] FILL_INSTR   = FILL_INSTR_DEFAULT[INSTR_WIDTH-1:0]
)
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [PC_WIDTH-1:0]    PC,
  input  logic                   fetch_req,
  output logic [INSTR_WIDTH-1:0] INSTRUCTION,
  output logic                   instr_valid,
  output logic                   addr_fault,
  output logic                   busy,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   load_done,
  input  logic                   reload
`ifdef IMEM_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef IMEM_PARITY_EN
  localparam int FLAG_W = 2;
  localparam int MEM_W  = INSTR_WIDTH + 1;

  function automatic logic even_par(input logic [INSTR_WIDTH-1:0] w);
    return ^w;
  endfunction
`else
  localparam int FLAG_W = 1;
  localparam int MEM_W  = INSTR_WIDTH;
`endif

  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_lat_chk
    $fatal(1, "instr_fetch_mem: READ_LATENCY %0d outside 1..4", READ_LATENCY);
  end

  imem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  load_addr_q, load_addr_d;
  logic                   load_done_q, load_done_d;
  logic                   busy_q, load_ready_q;
  logic                   mem_we_s;
  logic                   fetch_acc_s;
  logic                   oor_s;
  logic [MEM_W-1:0]       mem_q [DEPTH];
  logic [MEM_W-1:0]       wr_word_s, rd_word_s;
  logic [INSTR_WIDTH-1:0] rd_data_s;
  logic [FLAG_W-1:0]      rd_flags_s, pipe_flags_s;

  // Load sequencing; reload takes priority over everything else
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    load_done_d = load_done_q;
    mem_we_s    = 1'b0;
    if (reload) begin
      state_d     = S_LOAD;
      load_addr_d = '0;
      load_done_d = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_valid) begin
            mem_we_s = ~RESET;
            if (load_last || (load_addr_q == {ADDR_WIDTH{1'b1}})) begin
              state_d     = S_RUN;
              load_done_d = 1'b1;
              load_addr_d = '0;
            end else begin
              load_addr_d = load_addr_q + ADDR_WIDTH'(1);
            end
          end else begin
            load_addr_d = load_addr_q;
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d     = S_LOAD;
          load_addr_d = '0;
        end
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_LOAD;
      load_addr_q  <= '0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      load_addr_q  <= load_addr_d;
      load_done_q  <= load_done_d;
      busy_q       <= (state_d == S_LOAD);
      load_ready_q <= (state_d == S_LOAD);
    end
  end

`ifdef IMEM_PARITY_EN
  assign wr_word_s = {even_par(load_data), load_data};
`else
  assign wr_word_s = load_data;
`endif

  // Program storage; contents survive RESET
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_q[load_addr_q] <= wr_word_s;
    end
  end

  assign fetch_acc_s = (state_q == S_RUN) && fetch_req && !reload && !RESET;

  // Read lookup; out-of-range and corrupted words are replaced by the fill word
  always_comb begin
    rd_word_s  = mem_q[PC[ADDR_WIDTH-1:0]];
    oor_s      = (PC >= PC_WIDTH'(DEPTH));
    rd_data_s  = rd_word_s[INSTR_WIDTH-1:0];
    rd_flags_s = '0;
`ifdef IMEM_PARITY_EN
    rd_flags_s = {(^rd_word_s) & ~oor_s, oor_s};
    if (oor_s || rd_flags_s[1]) begin
      rd_data_s = FILL_INSTR;
    end else begin
      rd_data_s = rd_word_s[INSTR_WIDTH-1:0];
    end
`else
    rd_flags_s = oor_s;
    if (oor_s) begin
      rd_data_s = FILL_INSTR;
    end else begin
      rd_data_s = rd_word_s;
    end
`endif
  end

  imem_read_pipe #(
    .DATA_W     (INSTR_WIDTH),
    .FLAG_W     (FLAG_W),
    .LATENCY    (READ_LATENCY),
    .RESET_DATA (FILL_INSTR)
  ) u_pipe (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .flush_i (RESET | reload),
    .valid_i (fetch_acc_s),
    .data_i  (rd_data_s),
    .flags_i (rd_flags_s),
    .valid_o (instr_valid),
    .data_o  (INSTRUCTION),
    .flags_o (pipe_flags_s)
  );

  assign addr_fault = pipe_flags_s[0];
`ifdef IMEM_PARITY_EN
  assign parity_err = pipe_flags_s[1];
`endif
  assign busy       = busy_q;
  assign load_ready = load_ready_q;
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: four instances (READ_LATENCY 1..4) share stimulus;
// a scoreboard queue holds expected responses with their due cycle.
module tb_instr_fetch_mem;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req, load_valid, load_last, reload;
  logic [18:0] load_data;

  logic [18:0] instr_s  [NL];
  logic        valid_s  [NL];
  logic        fault_s  [NL];
  logic        busy_s   [NL];
  logic        lready_s [NL];
  logic        ldone_s  [NL];
`ifdef IMEM_PARITY_EN
  logic        perr_s   [NL];
`endif

  typedef struct {
    int          lane;
    logic [18:0] d;
    logic        f;
    logic        p;
    int          due;
  } exp_t;

  exp_t        exp_q [$];
  logic [18:0] mem_m [128];
  logic        run_m;
  int          laddr_m;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  for (genvar l = 0; l < NL; l++) begin : g_lane
    instr_fetch_mem #(.READ_LATENCY(l + 1)) u_dut (
      .CLK         (clk),
      .RESET       (rst),
      .PC          (pc),
      .fetch_req   (fetch_req),
      .INSTRUCTION (instr_s[l]),
      .instr_valid (valid_s[l]),
      .addr_fault  (fault_s[l]),
      .busy        (busy_s[l]),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (lready_s[l]),
      .load_done   (ldone_s[l]),
      .reload      (reload)
`ifdef IMEM_PARITY_EN
      ,
      .parity_err  (perr_s[l])
`endif
    );

    always @(negedge clk) begin
      int idx;
      if (valid_s[l]) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (idx < 0 && exp_q[i].lane == l) idx = i;
        end
        check($sformatf("lane%0d expected-valid", l), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          check($sformatf("lane%0d latency", l), cyc, exp_q[idx].due);
          check($sformatf("lane%0d data", l), 32'(instr_s[l]), 32'(exp_q[idx].d));
          check($sformatf("lane%0d addr_fault", l), 32'(fault_s[l]), 32'(exp_q[idx].f));
`ifdef IMEM_PARITY_EN
          check($sformatf("lane%0d parity_err", l), 32'(perr_s[l]), 32'(exp_q[idx].p));
`endif
          exp_q.delete(idx);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [31:0] p, input logic perr);
    for (int l = 0; l < NL; l++) begin
      exp_t e;
      e.lane = l;
      e.due  = cyc + l + 1;
      e.p    = perr;
      if (p >= 32'd128) begin
        e.d = 19'h0;
        e.f = 1'b1;
      end else if (perr) begin
        e.d = 19'h0;
        e.f = 1'b0;
      end else begin
        e.d = mem_m[p[6:0]];
        e.f = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic fetch_p(input logic [31:0] p, input logic perr);
    pc        = p;
    fetch_req = 1'b1;
    if (run_m) push(p, perr);
    step();
    fetch_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] p);
    fetch_p(p, 1'b0);
  endtask

  task automatic load_word(input logic [18:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    if (!run_m) begin
      mem_m[laddr_m] = d;
      if (last || laddr_m == 127) begin
        run_m   = 1'b1;
        laddr_m = 0;
      end else begin
        laddr_m++;
      end
    end
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    run_m   = 1'b0;
    laddr_m = 0;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    idle(8);
    check({tag, " pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_ctrl(input string tag, input logic b, input logic d);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("%s lane%0d busy", tag, l), 32'(busy_s[l]), 32'(b));
      check($sformatf("%s lane%0d load_ready", tag, l), 32'(lready_s[l]), 32'(b));
      check($sformatf("%s lane%0d load_done", tag, l), 32'(ldone_s[l]), 32'(d));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] prog [7];
    prog = '{19'h40402, 19'h40C21, 19'h00443, 19'h09024, 19'h48002, 19'h41011, 19'h4100A};
    rst = 1'b1; pc = 32'd0; fetch_req = 1'b0; load_valid = 1'b0;
    load_last = 1'b0; reload = 1'b0; load_data = 19'h0;
    run_m = 1'b0; laddr_m = 0;

    // Reset state
    do_reset();
    for (int l = 0; l < NL; l++) begin
      check($sformatf("reset lane%0d INSTRUCTION", l), 32'(instr_s[l]), 32'd0);
      check($sformatf("reset lane%0d instr_valid", l), 32'(valid_s[l]), 32'd0);
      check($sformatf("reset lane%0d addr_fault", l), 32'(fault_s[l]), 32'd0);
    end
    check_ctrl("reset", 1'b1, 1'b0);

    // Program load with load_last on word 6
    for (int i = 0; i < 6; i++) load_word(prog[i], 1'b0);
    check_ctrl("mid-load", 1'b1, 1'b0);
    load_word(prog[6], 1'b1);
    check_ctrl("post-load", 1'b0, 1'b1);

    // Back-to-back burst, then a lone fetch for the latency sweep
    for (int i = 0; i < 7; i++) fetch(32'(i));
    drain("burst");
    fetch(32'd3);
    drain("single");

    // Out-of-range then in-range; INSTRUCTION must hold afterwards
    fetch(32'd200);
    fetch(32'd2);
    drain("oor");
    for (int l = 0; l < NL; l++) begin
      check($sformatf("hold lane%0d INSTRUCTION", l), 32'(instr_s[l]), 32'h00443);
      check($sformatf("hold lane%0d addr_fault", l), 32'(fault_s[l]), 32'd0);
    end

    // load_valid in RUN must not write
    load_word(19'h12345, 1'b0);
    fetch(32'd0);
    drain("run-load-ignored");

    // Reload in the PC=1 request cycle
    fetch(32'd0);
    pc = 32'd1; fetch_req = 1'b1; reload = 1'b1;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due > cyc) exp_q.delete(i);
    end
    step();
    reload = 1'b0; fetch_req = 1'b0;
    run_m = 1'b0; laddr_m = 0;
    fetch(32'd2);
    drain("reload");
    check_ctrl("after-reload", 1'b1, 1'b0);
    load_word(19'h7FFFF, 1'b1);
    check_ctrl("reload-done", 1'b0, 1'b1);
    fetch(32'd0);
    drain("reload-fetch");

    // Full-depth load without load_last
    reload = 1'b1;
    step();
    reload = 1'b0;
    run_m = 1'b0; laddr_m = 0;
    for (int i = 0; i < 127; i++) load_word(19'(i), 1'b0);
    check_ctrl("full-127", 1'b1, 1'b0);
    load_word(19'd127, 1'b0);
    check_ctrl("full-done", 1'b0, 1'b1);
    fetch(32'd127);
    fetch(32'd64);
    drain("full");

    // RESET mid-load: fetch in LOAD is dropped, loading restarts at 0
    do_reset();
    load_word(19'h11111, 1'b0);
    load_word(19'h22222, 1'b0);
    load_word(19'h33333, 1'b0);
    do_reset();
    check_ctrl("reset-mid-load", 1'b1, 1'b0);
    fetch(32'd0);
    drain("fetch-in-load");
    load_word(19'h55555, 1'b1);
    fetch(32'd0);
    fetch(32'd1);
    fetch(32'd2);
    drain("restart");

`ifdef IMEM_PARITY_EN
    // Corrupt words 1 and 2 in every lane; both must be reported
    g_lane[0].u_dut.mem_q[1][0] = ~g_lane[0].u_dut.mem_q[1][0];
    g_lane[1].u_dut.mem_q[1][0] = ~g_lane[1].u_dut.mem_q[1][0];
    g_lane[2].u_dut.mem_q[1][0] = ~g_lane[2].u_dut.mem_q[1][0];
    g_lane[3].u_dut.mem_q[1][0] = ~g_lane[3].u_dut.mem_q[1][0];
    g_lane[0].u_dut.mem_q[2][3] = ~g_lane[0].u_dut.mem_q[2][3];
    g_lane[1].u_dut.mem_q[2][3] = ~g_lane[1].u_dut.mem_q[2][3];
    g_lane[2].u_dut.mem_q[2][3] = ~g_lane[2].u_dut.mem_q[2][3];
    g_lane[3].u_dut.mem_q[2][3] = ~g_lane[3].u_dut.mem_q[2][3];
    fetch_p(32'd1, 1'b1);
    fetch_p(32'd2, 1'b1);
    fetch_p(32'd0, 1'b0);
    drain("parity");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
